// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that pushes one nibble per clock through a single 4-bit CLA

// 4-bit carry-lookahead adder: all carries come straight from generate/propagate terms
module carryLook_4bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
        S    = p ^ c[3:0];
        Cout = c[4];
    end
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [3:0]       cla_a, cla_b, cla_s;
    logic             cla_cout;

    carryLook_4bit_adder u_cla (
        .A   (cla_a),
        .B   (cla_b),
        .Cin (carry_q),
        .S   (cla_s),
        .Cout(cla_cout)
    );

    // Steer the current nibble of the latched operands into the CLA
    always_comb begin
        cla_a = a_q[4*idx_q +: 4];
        cla_b = b_q[4*idx_q +: 4];
    end

    // Next-state and datapath updates; sign of the final nibble decides overflow
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                carry_d = Cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                s_d[4*idx_q +: 4] = cla_s;
                carry_d           = cla_cout;
                idx_d             = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    cout_d  = cla_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_s[3] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags follow the state directly
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        S         = s_q;
        Cout      = cout_q;
        Ovf       = ovf_q;
    end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed checks of the nibble-serial CLA adder
module tb_cla_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, Cin, out_valid, out_ready, Cout, Ovf;
    logic [15:0] A, B, S;
    int          n_tests = 0;
    int          n_fail  = 0;

    cla_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .Ovf      (Ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for out_valid; returns cycles after accept edge
    task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  output int lat);
        A = a; B = b; Cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        start_and_wait(a, b, c, lat);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_s"}, S, es);
        check({tag, "_cout"}, Cout, ec);
        check({tag, "_ovf"}, Ovf, eo);
        check({tag, "_inrdy"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, out_valid, 0);
        check({tag, "_inrdy_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #12;
        check("rst_inrdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_s", S, 0);
        check("rst_cout", Cout, 0);
        check("rst_ovf", Ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        start_and_wait(16'hFFFF, 16'hFFFF, 1'b1, lat);
        check("t4_lat", lat, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_vld", out_valid, 1);
            check("t4_hold_s", S, 16'hFFFF);
            check("t4_hold_cout", Cout, 1);
            check("t4_hold_ovf", Ovf, 0);
            check("t4_hold_inrdy", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_vld_drop", out_valid, 0);

        A = 16'h1111; B = 16'h2222; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        A = 16'h0F0F; B = 16'h0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("t5_lat", lat, 4);
        check("t5_s", S, 16'h3333);
        check("t5_cout", Cout, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("t5_no_auto_start", in_ready, 1);
        do_op("t5b", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

        A = 16'h1234; B = 16'h1111; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_run_inrdy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_s", S, 0);
        check("t6_async_inrdy", in_ready, 1);
        check("t6_async_vld", out_valid, 0);
        check("t6_async_cout", Cout, 0);
        check("t6_async_ovf", Ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op("t6", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
